lcd_frame_sequencer: RTL
========================

// Module: lcd_frame_sequencer
// PURPOSE
//  Command initiator for the FPGA_2_LCD character-LCD driver; the driver is the responder side of that handshake.
//  After reset it runs the HD44780 init sequence, then writes display frames on request or on input change.
//  Line 1 of a frame shows the 24-bit BCD counted time; line 2 shows the set-time mode and minutes.
//  Runs on the divided LCD clock and replaces the serial path into the driver with direct parallel issue.
// PARAMETERS
//  RST_CYCLES    4  cycles drv_RST is held high at start of init (>=1)
//  AUTO_REFRESH  1  1: start a frame when {setTime,timeIn,countedTime} differs from last displayed snapshot
// PORTS
//  clk          in   1   LCD-domain clock (divided clock)
//  RST          in   1   synchronous active-high reset
//  frame_req    in   1   1-cycle pulse: request a display refresh
//  setTime      in   1   1: time-setting mode
//  timeIn       in   6   minutes being set, binary 0..63
//  countedTime  in   24  BCD {h1,h0,m1,m0,s1,s0}, 4 bits per digit
//  RDY          in   1   driver ready for next operation
//  DATA         out  8   byte to driver
//  OPER         out  1   0 = instruction (RS=0), 1 = data write (RS=1)
//  ENB          out  1   1-cycle issue strobe to driver
//  drv_RST      out  1   reset to driver
//  busy         out  1   init or frame in progress
//  frame_done   out  1   1-cycle pulse after the last byte of a frame is accepted
// BEHAVIOUR
//  Reset: DATA=0, OPER=0, ENB=0, drv_RST=1, busy=1, frame_done=0; pending=0; snapshot invalid; state=DRST.
//  Reset mid-operation aborts everything and restarts init; no partial byte is issued after RST.
//  FSM: DRST -> INIT -> IDLE -> LATCH -> ISSUE <-> WAIT -> DONE -> IDLE.
//  DRST: drv_RST=1 for RST_CYCLES cycles counted from RST release, then 0; go INIT.
//  INIT: issues instructions 0x38, 0x0C, 0x06, 0x01 in order; then IDLE, busy=0. A frame is pending after init.
//  Issue rule: in ISSUE with RDY=1, set DATA/OPER and pulse ENB for 1 cycle. RDY=0 holds ISSUE, ENB=0.
//  DATA/OPER stay stable until the next issue.
//  WAIT: the first cycle after ENB ignores RDY; the driver drops RDY within 1 cycle of ENB.
//  WAIT then holds until RDY=1 and returns to ISSUE for the next byte. Only one ENB per RDY handshake.
//  IDLE: start a frame if frame_req=1, or pending=1, or (AUTO_REFRESH and inputs != snapshot).
//  LATCH: 1 cycle; copies setTime/timeIn/countedTime into the snapshot; busy=1.
//  The frame uses only the snapshot, so input changes mid-frame do not affect bytes in flight.
//  Frame order is 18 bytes:
//    - instr 0x80, then 8 data chars "h1h0:m1m0:s1s0";
//    - instr 0xC0, then 8 data chars for line 2.
//  Line 2 with setTime=1: "SET " + tens + units of timeIn + "  ".
//  Line 2 with setTime=0: "RUN     ".
//  Digit char = 0x30+d for d<=9; BCD nibble >9 renders as '?' (0x3F).
//  timeIn decimal conversion is combinational on the snapshot; range 0..63, e.g. 63 -> "63", 7 -> "07".
//  frame_req while busy sets pending; multiple requests collapse to one. pending clears at LATCH.
//  DONE: frame_done=1 for 1 cycle, busy=0 next cycle, then IDLE.
//  frame_req in the DONE cycle is honoured through pending.
//  Latency: frame_req in IDLE with RDY held 1 -> first ENB 2 cycles later (LATCH, ISSUE).
// TESTING
//  1 Reset, RDY=1 model driver: drv_RST high 4 cycles; ENB bytes 38,0C,06,01, then an 18-byte frame; busy falls.
//  2 countedTime=0x125907, setTime=0, frame_req: bytes 80,31,32,3A,35,39,3A,30,37,C0,52,55,4E,20x5; frame_done once.
//  3 setTime=1, timeIn=42: line-2 bytes 53,45,54,20,34,32,20,20; timeIn=5 gives 30,35.
//  4 Driver holds RDY=0 for 50 cycles after each ENB: no extra ENB; DATA stable; order unchanged.
//  5 Three frame_req pulses plus a countedTime change mid-frame: exactly one extra frame, using the new value.
//  6 RST mid-frame (byte 9): ENB stops; drv_RST reasserts; full init repeats; countedTime=0x00000A shows '?'.

Source files
------------

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer
//   Command initiator for the character-LCD driver. After reset it pulses the
//   driver reset, runs the HD44780 init sequence (0x38, 0x0C, 0x06, 0x01) and
//   then writes 18-byte display frames on request or when the displayed inputs
//   change. Line 1 shows the BCD counted time as "hh:mm:ss"; line 2 shows
//   either "SET nn  " (set-time mode, minutes in decimal) or "RUN     ".
//   Every byte is issued with a RDY/ENB handshake: one ENB pulse per RDY.
// Ports
//   clk          LCD-domain clock
//   RST          synchronous active-high reset
//   frame_req    1-cycle refresh request pulse
//   setTime      set-time mode flag
//   timeIn       minutes being set, binary 0..63
//   countedTime  BCD {h1,h0,m1,m0,s1,s0}
//   RDY          driver ready for the next operation
//   DATA/OPER    byte and RS select to the driver (OPER=1 for data writes)
//   ENB          1-cycle issue strobe
//   drv_RST      reset to the driver
//   busy         init or frame in progress
//   frame_done   1-cycle pulse once the last frame byte has been accepted
module lcd_frame_sequencer #(
  parameter int RST_CYCLES   = 4,
  parameter bit AUTO_REFRESH = 1'b1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        frame_req,
  input  logic        setTime,
  input  logic [5:0]  timeIn,
  input  logic [23:0] countedTime,
  input  logic        RDY,
  output logic [7:0]  DATA,
  output logic        OPER,
  output logic        ENB,
  output logic        drv_RST,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_DRST  = 3'd0,
    S_INIT  = 3'd1,
    S_IDLE  = 3'd2,
    S_LATCH = 3'd3,
    S_ISSUE = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [7:0] CNT_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [4:0] LAST_INIT  = 5'd3;
  localparam logic [4:0] LAST_FRAME = 5'd17;

  // BCD nibble to ASCII; nibbles above 9 are shown as '?'.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    if (d <= 4'd9) begin
      return 8'h30 + {4'h0, d};
    end else begin
      return 8'h3F;
    end
  endfunction

  // Tens digit of a 0..63 binary value.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd60) begin
      return 4'd6;
    end else if (v >= 6'd50) begin
      return 4'd5;
    end else if (v >= 6'd40) begin
      return 4'd4;
    end else if (v >= 6'd30) begin
      return 4'd3;
    end else if (v >= 6'd20) begin
      return 4'd2;
    end else if (v >= 6'd10) begin
      return 4'd1;
    end else begin
      return 4'd0;
    end
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic        in_init_q, in_init_d;
  logic        wait_skip_q, wait_skip_d;
  logic        pending_q, pending_d;
  logic        snap_valid_q, snap_valid_d;
  logic        snap_set_q, snap_set_d;
  logic [5:0]  snap_time_q, snap_time_d;
  logic [23:0] snap_cnt_q, snap_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        oper_q, oper_d;
  logic        enb_q, enb_d;
  logic        drv_rst_q, drv_rst_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  logic [3:0]  tens_s;
  logic [3:0]  units_s;
  logic [7:0]  init_byte_s;
  logic [7:0]  frame_byte_s;
  logic        frame_oper_s;
  logic        snap_diff_s;
  logic        last_byte_s;

  assign tens_s      = tens_of(snap_time_q);
  assign units_s     = 4'(snap_time_q - ({2'b00, tens_s} * 6'd10));
  assign snap_diff_s = !snap_valid_q ||
                       ({setTime, timeIn, countedTime} != {snap_set_q, snap_time_q, snap_cnt_q});
  assign last_byte_s = in_init_q ? (idx_q == LAST_INIT) : (idx_q == LAST_FRAME);

  // Init instruction table indexed by the byte counter.
  always_comb begin
    init_byte_s = 8'h38;
    case (idx_q[1:0])
      2'd0:    init_byte_s = 8'h38;
      2'd1:    init_byte_s = 8'h0C;
      2'd2:    init_byte_s = 8'h06;
      2'd3:    init_byte_s = 8'h01;
      default: init_byte_s = 8'h38;
    endcase
  end

  // Frame byte table, rendered only from the latched snapshot.
  always_comb begin
    frame_byte_s = 8'h20;
    frame_oper_s = 1'b1;
    case (idx_q)
      5'd0:  begin frame_byte_s = 8'h80; frame_oper_s = 1'b0; end
      5'd1:  frame_byte_s = digit_char(snap_cnt_q[23:20]);
      5'd2:  frame_byte_s = digit_char(snap_cnt_q[19:16]);
      5'd3:  frame_byte_s = 8'h3A;
      5'd4:  frame_byte_s = digit_char(snap_cnt_q[15:12]);
      5'd5:  frame_byte_s = digit_char(snap_cnt_q[11:8]);
      5'd6:  frame_byte_s = 8'h3A;
      5'd7:  frame_byte_s = digit_char(snap_cnt_q[7:4]);
      5'd8:  frame_byte_s = digit_char(snap_cnt_q[3:0]);
      5'd9:  begin frame_byte_s = 8'hC0; frame_oper_s = 1'b0; end
      5'd10: frame_byte_s = snap_set_q ? 8'h53 : 8'h52;
      5'd11: frame_byte_s = snap_set_q ? 8'h45 : 8'h55;
      5'd12: frame_byte_s = snap_set_q ? 8'h54 : 8'h4E;
      5'd14: frame_byte_s = snap_set_q ? digit_char(tens_s) : 8'h20;
      5'd15: frame_byte_s = snap_set_q ? digit_char(units_s) : 8'h20;
      default: frame_byte_s = 8'h20;
    endcase
  end

  // Next-state and registered-output decode for the sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    in_init_d    = in_init_q;
    wait_skip_d  = 1'b0;
    pending_d    = pending_q;
    snap_valid_d = snap_valid_q;
    snap_set_d   = snap_set_q;
    snap_time_d  = snap_time_q;
    snap_cnt_d   = snap_cnt_q;
    data_d       = data_q;
    oper_d       = oper_q;
    enb_d        = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_DRST: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = S_INIT;
          idx_d     = 5'd0;
          in_init_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_INIT, S_ISSUE: begin
        if (RDY) begin
          data_d      = (state_q == S_INIT) ? init_byte_s : frame_byte_s;
          oper_d      = (state_q == S_INIT) ? 1'b0 : frame_oper_s;
          enb_d       = 1'b1;
          wait_skip_d = 1'b1;
          state_d     = S_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT: begin
        // The cycle right after ENB still sees the driver's stale RDY.
        if (wait_skip_q) begin
          state_d = S_WAIT;
        end else if (RDY && last_byte_s && in_init_q) begin
          state_d   = S_IDLE;
          in_init_d = 1'b0;
          pending_d = 1'b1;
        end else if (RDY && last_byte_s) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end else if (RDY) begin
          idx_d   = idx_q + 5'd1;
          state_d = in_init_q ? S_INIT : S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IDLE: begin
        if (frame_req || pending_q || (AUTO_REFRESH && snap_diff_s)) begin
          state_d = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        snap_valid_d = 1'b1;
        snap_set_d   = setTime;
        snap_time_d  = timeIn;
        snap_cnt_d   = countedTime;
        pending_d    = 1'b0;
        idx_d        = 5'd0;
        state_d      = S_ISSUE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_DRST;
        cnt_d   = 8'd0;
      end
    endcase
    // Requests arriving while not idle collapse into a single pending frame.
    pending_d = pending_d | (frame_req && (state_q != S_IDLE));
    busy_d    = (state_d != S_IDLE);
    drv_rst_d = (state_d == S_DRST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= S_DRST;
      cnt_q        <= 8'd0;
      idx_q        <= 5'd0;
      in_init_q    <= 1'b0;
      wait_skip_q  <= 1'b0;
      pending_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_set_q   <= 1'b0;
      snap_time_q  <= 6'd0;
      snap_cnt_q   <= 24'd0;
      data_q       <= 8'd0;
      oper_q       <= 1'b0;
      enb_q        <= 1'b0;
      drv_rst_q    <= 1'b1;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      in_init_q    <= in_init_d;
      wait_skip_q  <= wait_skip_d;
      pending_q    <= pending_d;
      snap_valid_q <= snap_valid_d;
      snap_set_q   <= snap_set_d;
      snap_time_q  <= snap_time_d;
      snap_cnt_q   <= snap_cnt_d;
      data_q       <= data_d;
      oper_q       <= oper_d;
      enb_q        <= enb_d;
      drv_rst_q    <= drv_rst_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign DATA       = data_q;
  assign OPER       = oper_q;
  assign ENB        = enb_q;
  assign drv_RST    = drv_rst_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
